sw_conditioner: RTL and testbench

Upstream conditioning stage for the board switches. It synchronises and debounces the raw SWI bus and emits a clean switch image. The downstream counter/control logic consumes that image as reset, counter_on, count_up, load and Data_in. The block also produces one-cycle rise/fall pulses per bit and a prioritised "last event" report that can be shown on LEDs or the LCD.

---
 rtl/sw_conditioner.sv | 84 ++++++++
 tb/tb_sw_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sw_conditioner.sv
// Switch conditioner: two-flop synchroniser, per-bit debounce, registered
// rise/fall pulses and a lowest-index "last event" report.
module sw_conditioner #(
    parameter int  NBITS           = 8,
    parameter int  DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    localparam int IDX_W           = $clog2(NBITS)
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] SWI_raw,
    output logic [NBITS-1:0] SWI_clean,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    output logic             event_valid,
    output logic [IDX_W-1:0] event_idx,
    output logic             event_dir,
    output logic             event_multi
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [CNT_W-1:0] cnt      [NBITS];
    logic [CNT_W-1:0] cnt_next [NBITS];
    logic [NBITS-1:0] clean_next;
    logic [NBITS-1:0] changed;
    logic [IDX_W-1:0] low_idx;
    logic             multi;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        clean_next = SWI_clean;
        for (int i = 0; i < NBITS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != SWI_clean[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    clean_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end

        changed = clean_next ^ SWI_clean;
        low_idx = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (changed[i]) low_idx = IDX_W'(i);
        end
        // Clearing the lowest set bit leaves something only if two or more bits changed.
        multi = |(changed & (changed - NBITS'(1)));
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            SWI_clean   <= '0;
            rise        <= '0;
            fall        <= '0;
            event_valid <= 1'b0;
            event_idx   <= '0;
            event_dir   <= 1'b0;
            event_multi <= 1'b0;
            for (int i = 0; i < NBITS; i++) cnt[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1       <= SWI_raw;
            sync2       <= sync1;
            SWI_clean   <= clean_next;
            cnt         <= cnt_next;
            rise        <= changed & clean_next;
            fall        <= changed & ~clean_next;
            event_valid <= |changed;
            if (|changed) begin
                event_idx   <= low_idx;
                event_dir   <= clean_next[low_idx];
                event_multi <= multi;
            end
        end
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: a D=4 instance checked through an event scoreboard
// and a D=1 instance checked directly cycle by cycle.
module tb_sw_conditioner;

    typedef struct {
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] clean;
        logic [2:0] idx;
        logic       dir;
        logic       multi;
    } exp_t;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] raw   = '0;
    logic [7:0] clean, rise, fall;
    logic       ev_valid, ev_dir, ev_multi;
    logic [2:0] ev_idx;

    logic [7:0] raw1 = '0;
    logic [7:0] clean1, rise1, fall1;
    logic       ev_valid1, ev_dir1, ev_multi1;
    logic [2:0] ev_idx1;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_2 = ~clk_2;

    sw_conditioner #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk_2(clk_2), .reset(reset), .SWI_raw(raw), .SWI_clean(clean),
        .rise(rise), .fall(fall), .event_valid(ev_valid), .event_idx(ev_idx),
        .event_dir(ev_dir), .event_multi(ev_multi)
    );

    sw_conditioner #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk_2(clk_2), .reset(reset), .SWI_raw(raw1), .SWI_clean(clean1),
        .rise(rise1), .fall(fall1), .event_valid(ev_valid1), .event_idx(ev_idx1),
        .event_dir(ev_dir1), .event_multi(ev_multi1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_2);
            @(negedge clk_2);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] f, input logic [7:0] c,
                        input logic [2:0] idx, input logic dir, input logic multi);
        exp_t e;
        e.rise = r; e.fall = f; e.clean = c; e.idx = idx; e.dir = dir; e.multi = multi;
        q.push_back(e);
    endtask

    // Monitor: every event the D=4 instance reports must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_2);
            #1;
            if (reset) continue;
            if (ev_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: rise=%0h fall=%0h clean=%0h, expected no event",
                             rise, fall, clean);
                end else begin
                    e = q.pop_front();
                    check("ev_rise",  32'(rise),     32'(e.rise));
                    check("ev_fall",  32'(fall),     32'(e.fall));
                    check("ev_clean", 32'(clean),    32'(e.clean));
                    check("ev_idx",   32'(ev_idx),   32'(e.idx));
                    check("ev_dir",   32'(ev_dir),   32'(e.dir));
                    check("ev_multi", 32'(ev_multi), 32'(e.multi));
                end
            end else if ((rise | fall) != 8'h00) begin
                n_tests++;
                n_fail++;
                $display("FAIL pulse_without_event: rise=%0h fall=%0h, expected 0", rise, fall);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_clean", 32'(clean), 32'h00);
        check("rst_rise",  32'(rise),  32'h00);
        check("rst_fall",  32'(fall),  32'h00);
        check("rst_valid", 32'(ev_valid), 32'h0);
        check("rst_idx",   32'({ev_idx, ev_dir, ev_multi}), 32'h0);
        @(negedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;

        // 1: quiet input for 20 cycles
        tick(20);
        check("quiet_clean", 32'(clean), 32'h00);

        // 2: single rise, clean must appear after edge 5 and not earlier
        raw = 8'h01;
        push(8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("lat_pre_edge%0d", i), 32'(clean), 32'h00);
        end
        tick();
        check("lat_edge5_clean", 32'(clean), 32'h01);
        tick();
        check("rise_one_cycle", 32'(rise), 32'h00);

        // 3: 3-cycle glitch on bit 3 must be rejected
        raw = 8'h09;
        tick(3);
        raw = 8'h01;
        tick(10);
        check("glitch_clean", 32'(clean), 32'h01);

        // 4: 0x0F -> 0xF0 in one step
        raw = 8'h0F;
        push(8'h0E, 8'h00, 8'h0F, 3'd1, 1'b1, 1'b1);
        tick(8);
        check("pre_swap_clean", 32'(clean), 32'h0F);
        raw = 8'hF0;
        push(8'hF0, 8'h0F, 8'hF0, 3'd0, 1'b0, 1'b1);
        tick(8);
        check("held_valid", 32'(ev_valid), 32'h0);
        check("held_idx",   32'(ev_idx),   32'h0);
        check("held_dir",   32'(ev_dir),   32'h0);
        check("held_multi", 32'(ev_multi), 32'h1);

        // 5: clear, then reset in the middle of a debounce on bit 7
        raw = 8'h00;
        push(8'h00, 8'hF0, 8'h00, 3'd4, 1'b0, 1'b1);
        tick(8);
        raw = 8'h80;
        push(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0); // sentinel, removed below
        q.pop_back();
        push(8'h80, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0);
        tick(3);
        check("mid_deb_clean", 32'(clean), 32'h00);
        tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_outs", 32'({clean, rise, fall}), 32'h0);
        check("async_rst_ev",   32'({ev_valid, ev_idx, ev_dir, ev_multi}), 32'h0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post_rst_edge%0d", i), 32'(clean), 32'h00);
        end
        tick();
        check("post_rst_clean", 32'(clean), 32'h80);
        tick(3);

        // 6: D=1 instance: update at edge 2, and a 1-cycle glitch is accepted
        raw1 = 8'h04;
        tick();
        check("d1_edge0", 32'(clean1), 32'h00);
        tick();
        check("d1_edge1", 32'(clean1), 32'h00);
        tick();
        check("d1_edge2_clean", 32'(clean1), 32'h04);
        check("d1_edge2_rise",  32'(rise1),  32'h04);
        check("d1_edge2_ev",    32'({ev_valid1, ev_idx1, ev_dir1, ev_multi1}), 32'b1_010_1_0);
        tick(3);
        raw1 = 8'h05;
        tick();
        raw1 = 8'h04;
        tick();
        check("d1_glitch_e1", 32'(clean1), 32'h04);
        tick();
        check("d1_glitch_clean", 32'(clean1), 32'h05);
        check("d1_glitch_rise",  32'(rise1),  32'h01);
        tick();
        check("d1_glitch_back",  32'(clean1), 32'h04);
        check("d1_glitch_fall",  32'(fall1),  32'h01);
        check("d1_glitch_ev",    32'({ev_valid1, ev_idx1, ev_dir1, ev_multi1}), 32'b1_000_0_0);

        tick(2);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
